// File: rtl/cskip_pkg.sv
// Shared constants, stage control payload and saturation helper for the pipelined carry-skip adder.
// Optional saturation support is enabled with the CSKIP_SAT_EN macro.
package cskip_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_BLOCK  = 4;
  localparam int DEF_STAGES = 2;
  localparam int SAT_MAX_W  = 64;

  // Control part of a stage register; the wide operand/sum vectors live in the top
  // because their width follows the module parameter.
  typedef struct packed {
    logic valid;
    logic carry;
`ifdef CSKIP_SAT_EN
    logic sat;
`endif
  } stage_ctrl_t;

  function automatic logic skip_mux(input logic p, input logic ci, input logic rc);
    return p ? ci : rc;
  endfunction

  // Signed bound of a w-bit word: min (1000..0) when neg, else max (0111..1).
  function automatic logic [SAT_MAX_W-1:0] sat_bound(input logic neg, input int w);
    logic [SAT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i < w - 1)
        r[i] = !neg;
      else if (i == w - 1)
        r[i] = neg;
    end
    return r;
  endfunction

endpackage

// File: rtl/cskip_block.sv
// Combinational BLOCK-bit carry-skip cell: ripple adder inside, block carry bypasses
// the ripple chain when every bit propagates.
module cskip_block
  import cskip_pkg::*;
#(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);

  logic rc;
  logic p;

  always_comb begin
    rc = ci;
    p  = 1'b1;
    s  = '0;
    for (int i = 0; i < BLOCK; i++) begin
      s[i] = a[i] ^ b[i] ^ rc;
      rc   = (a[i] & b[i]) | ((a[i] ^ b[i]) & rc);
      p    = p & (a[i] ^ b[i]);
    end
    co = skip_mux(p, ci, rc);
  end

endmodule

// File: rtl/cskip_adder_pipe.sv
// Skewed pipelined carry-skip adder/subtractor with valid/ready on both sides.
// Define CSKIP_SAT_EN to add the per-beat sat input (signed saturation of the result).
module cskip_adder_pipe
  import cskip_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int BLOCK  = DEF_BLOCK,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef CSKIP_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int S   = WIDTH / STAGES;
  localparam int BPS = S / BLOCK;
  localparam int NB  = WIDTH / BLOCK;
  localparam int L   = STAGES - 1;

  // Handshake: a beat moves on in_valid && in_ready, a result on out_valid && out_ready.
  // Stage k loads when it is empty or its successor loads; the last stage's successor is
  // the consumer. Hence a stalled full pipeline holds, and bubbles are squeezed out.

  stage_ctrl_t      r_ctrl  [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic             r_ovf;

  stage_ctrl_t      src_ctrl[STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [WIDTH-1:0] src_sum [STAGES];
  stage_ctrl_t      nxt_ctrl[STAGES];
  logic [WIDTH-1:0] nxt_sum [STAGES];
  logic [STAGES-1:0] nxt_c;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0] blk_s;
  logic [WIDTH-1:0] fin_sum;
  logic             fin_ovf;
  logic             c_msb;
`ifdef CSKIP_SAT_EN
  logic [SAT_MAX_W-1:0] bound;
`endif

  // Operands entering stage k: the port beat for stage 0, the previous register otherwise.
  // b is stored already conditioned (b' = sub ? ~b : b) so later stages need no sub bit.
  always_comb begin
    src_ctrl[0]       = '0;
    src_ctrl[0].valid = in_valid;
    src_ctrl[0].carry = cin;
`ifdef CSKIP_SAT_EN
    src_ctrl[0].sat   = sat;
`endif
    src_a[0]   = a;
    src_b[0]   = sub ? ~b : b;
    src_sum[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_ctrl[k] = r_ctrl[k-1];
      src_a[k]    = r_a[k-1];
      src_b[k]    = r_b[k-1];
      src_sum[k]  = r_sum[k-1];
    end
  end

  for (genvar j = 0; j < NB; j++) begin : g_blk
    localparam int K = j / BPS;
    logic ci;
    logic co;
    if (j % BPS == 0) begin : g_first
      assign ci = src_ctrl[K].carry;
    end else begin : g_chain
      assign ci = g_blk[j-1].co;
    end
    cskip_block #(.BLOCK(BLOCK)) u_blk (
      .a  (src_a[K][j*BLOCK +: BLOCK]),
      .b  (src_b[K][j*BLOCK +: BLOCK]),
      .ci (ci),
      .s  (blk_s[j*BLOCK +: BLOCK]),
      .co (co)
    );
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage_c
    assign nxt_c[k] = g_blk[(k+1)*BPS-1].co;
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt_ctrl[k]          = src_ctrl[k];
      nxt_ctrl[k].carry    = nxt_c[k];
      nxt_sum[k]           = src_sum[k];
      nxt_sum[k][k*S +: S] = blk_s[k*S +: S];
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit, avoiding an extra block port.
  always_comb begin
    fin_sum = nxt_sum[L];
    c_msb   = fin_sum[WIDTH-1] ^ src_a[L][WIDTH-1] ^ src_b[L][WIDTH-1];
    fin_ovf = c_msb ^ nxt_c[L];
`ifdef CSKIP_SAT_EN
    bound   = sat_bound(src_a[L][WIDTH-1], WIDTH);
    if (src_ctrl[L].sat && fin_ovf)
      fin_sum = bound[WIDTH-1:0];
`endif
  end

  always_comb begin
    load    = '0;
    load[L] = !r_ctrl[L].valid || out_ready;
    for (int k = L - 1; k >= 0; k--)
      load[k] = !r_ctrl[k].valid || load[k+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_ctrl[k] <= '0;
        r_a[k]    <= '0;
        r_b[k]    <= '0;
        r_sum[k]  <= '0;
      end
      r_ovf <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          r_ctrl[k] <= nxt_ctrl[k];
          r_a[k]    <= src_a[k];
          r_b[k]    <= src_b[k];
          r_sum[k]  <= (k == L) ? fin_sum : nxt_sum[k];
        end
      end
      if (load[L])
        r_ovf <= fin_ovf;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = r_ctrl[L].valid;
  assign sum       = r_sum[L];
  assign cout      = r_ctrl[L].carry;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_cskip_adder_pipe.sv
// Bench for cskip_adder_pipe at WIDTH=8, BLOCK=4, STAGES=2: vector table, latency,
// backpressure and reset sequences, then randomized traffic against an arithmetic model.
module tb_cskip_adder_pipe;

  localparam int W = 8;
`ifdef CSKIP_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         sat;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int compared   = 0;
  int mismatched = 0;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] cur_exp;
  logic [W+2:0] held;
  bit           stall_prev = 1'b0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         sat;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t tbl[9];

  cskip_adder_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
`ifdef CSKIP_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Packed as {sum, cout, ovf}; signed overflow judged from true integer range.
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                         input logic tcin, input logic tsub, input logic tsat);
    logic [W-1:0] bb;
    int unsigned  full;
    int           ss;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    bb   = tsub ? ~tb_v : tb_v;
    full = int'(ta) + int'(bb) + int'(tcin);
    s    = full[W-1:0];
    co   = full[W];
    ss   = int'($signed(ta)) + int'($signed(bb)) + int'(tcin);
    ov   = (ss > 127) || (ss < -128);
    if (SAT_EN && tsat && ov)
      s = (ss > 127) ? 8'h7F : 8'h80;
    return {s, co, ov};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                      input logic tsub, input logic tsat, input logic [W+1:0] texp,
                      output int waited);
    waited   = 0;
    a        = ta;
    b        = tb_v;
    cin      = tcin;
    sub      = tsub;
    sat      = tsat;
    cur_exp  = texp;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_%s: %0d results pending, required 0", tag, exp_q.size());
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        compared++;
        if ({out_valid, sum, cout, ovf} !== held) begin
          mismatched++;
          $display("FAIL stall_hold: got %03h, required %03h", {out_valid, sum, cout, ovf}, held);
        end
      end
      if (out_valid && out_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL result_unexpected: got sum=%02h cout=%0d ovf=%0d, required no result",
                   sum, cout, ovf);
        end else begin
          e = exp_q.pop_front();
          if ({sum, cout, ovf} !== e) begin
            mismatched++;
            $display("FAIL result: got sum=%02h cout=%0d ovf=%0d, required sum=%02h cout=%0d ovf=%0d",
                     sum, cout, ovf, e[W+1:2], e[1], e[0]);
          end
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(cur_exp);
      stall_prev = out_valid && !out_ready;
      held       = {out_valid, sum, cout, ovf};
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int waited;
    int total_wait;
    int lat;
    int seen;
    logic [W+1:0] e1;
    logic [W+1:0] e2;
    logic [W+1:0] e3;
    logic [W-1:0] corner[4];

    tbl[0] = '{8'hA0, 8'hA0, 1'b0, 1'b0, 1'b0, 8'h40, 1'b1, 1'b1};
    tbl[1] = '{8'h58, 8'hF4, 1'b0, 1'b0, 1'b0, 8'h4C, 1'b1, 1'b0};
    tbl[2] = '{8'h3D, 8'h0F, 1'b1, 1'b1, 1'b0, 8'h2E, 1'b1, 1'b0};
    tbl[3] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
`ifdef CSKIP_SAT_EN
    tbl[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1};
    tbl[5] = '{8'h80, 8'h01, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1};
`else
    tbl[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[5] = '{8'h80, 8'h01, 1'b1, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
`endif
    tbl[6] = '{8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[7] = '{8'h7F, 8'h7F, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
    tbl[8] = '{8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    corner[0] = 8'h00;
    corner[1] = 8'hFF;
    corner[2] = 8'h7F;
    corner[3] = 8'h80;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0; cur_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // vector table, back-to-back with the consumer always ready
    @(posedge clk);
    #1;
    total_wait = 0;
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].sat,
           {tbl[i].sum, tbl[i].cout, tbl[i].ovf}, waited);
      total_wait += waited;
    end
    check("table_throughput_stalls", 32'(total_wait), 32'd0);
    drain("table");

    // latency of a lone beat
    @(posedge clk);
    #1;
    send(8'hA0, 8'hA0, 1'b0, 1'b0, 1'b0, model(8'hA0, 8'hA0, 1'b0, 1'b0, 1'b0), waited);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check("latency_cycles", 32'(lat), 32'd2);
    drain("latency");

    // backpressure: consumer stalls while three beats are offered
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    e1 = model(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    e2 = model(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    e3 = model(8'h55, 8'h0A, 1'b1, 1'b1, 1'b0);
    send(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, e1, waited);
    send(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, e2, waited);
    fork
      send(8'h55, 8'h0A, 1'b1, 1'b1, 1'b0, e3, waited);
      begin
        repeat (5) @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_sum_held", 32'(sum), 32'(e1[W+1:2]));
        check("bp_queue_depth", 32'(exp_q.size()), 32'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("backpressure");

    // reset with two beats in flight
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, model(8'h11, 8'h22, 1'b0, 1'b0, 1'b0), waited);
    send(8'h33, 8'h44, 1'b0, 1'b0, 1'b0, model(8'h33, 8'h44, 1'b0, 1'b0, 1'b0), waited);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_outputs", 32'({sum, cout, ovf}), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("postrst_stale_results", 32'(seen), 32'd0);

    // randomized traffic with a randomly stalling consumer
    @(posedge clk);
    #1;
    begin
      bit done;
      done = 1'b0;
      fork
        begin
          for (int n = 0; n < 300; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic rc;
            logic rs;
            logic rt;
            ra = $urandom_range(0, 3) == 0 ? corner[$urandom_range(0, 3)] : W'($urandom);
            rb = $urandom_range(0, 3) == 0 ? corner[$urandom_range(0, 3)] : W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            rt = 1'($urandom);
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            send(ra, rb, rc, rs, rt, model(ra, rb, rc, rs, rt), waited);
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
          end
        end
      join
    end
    out_ready = 1'b1;
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
